logic_issue_stage: RTL and testbench
====================================

# logic_issue_stage

Upstream issue stage for the `logic_u` logic unit. It accepts operations {a, b, sel} over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It presents the FIFO head to `logic_u` combinationally and registers the returned result with its opcode and a zero flag on a valid/ready output port. It decouples the producer from the consumer and sustains one operation per cycle.

## Interface
- WIDTH, 32, operand/result width
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer offers an op
- in_ready  out  1  stage can accept; equals !full
- in_a  in  WIDTH  operand a
- in_b  in  WIDTH  operand b
- in_sel  in  3  logic opcode, passed through unchanged
- lu_a  out  WIDTH  to logic_u a; head entry a, 0 when empty
- lu_b  out  WIDTH  to logic_u b; head entry b, 0 when empty
- lu_sel  out  3  to logic_u sel; head entry sel, 0 when empty
- lu_out  in  WIDTH  combinational result from logic_u
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  registered lu_out
- out_sel  out  3  opcode of out_result
- out_zero  out  1  out_result == 0
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- ops_done  out  16  results consumed, wraps 0xFFFF→0

## Operation
- push = in_valid & in_ready; entry written at wr_ptr, wr_ptr increments mod DEPTH.
- load = (count != 0) & (!out_valid | out_ready). On load, out_result←lu_out, out_sel←head sel, out_zero←(lu_out==0), out_valid←1, and the head is popped (rd_ptr increments mod DEPTH).
- If out_valid & out_ready & !load: out_valid←0. out_result, out_sel and out_zero hold.
- ops_done increments on every out_valid & out_ready edge.
- count: +1 on push only, −1 on pop only, unchanged on push & pop.
- Full (count==DEPTH): in_ready=0, even if a pop happens this cycle. There is no same-cycle pass-through.
- Empty (count==0): no load; lu_* driven 0; a push is not visible on lu_* until the next cycle.
- out_result, out_sel and out_zero are stable while out_valid & !out_ready.
- Input signals are sampled only on push. While in_ready=0, in_* are don't-care.
- No opcode decoding in this block; sel is opaque.

## Timing
- Reset (async assert, sync-clean deassert internally not required): count=0, pointers=0, in_ready=1, out_valid=0, out_result=0, out_sel=0, out_zero=1, ops_done=0, lu_*=0.
- Reset asserted mid-operation immediately clears all state. In-flight FIFO contents and the pending result are discarded.
- Latency: op pushed at edge E is on lu_* after E. If the output is free, it is captured at E+1, so out_valid is high after E+1.
- Throughput: 1 op/cycle with out_ready held high and count<DEPTH.
- Backpressure: out_ready=0 stalls the result register. The FIFO then fills, and in_ready drops after DEPTH further pushes.
- Pointer wrap at DEPTH−1→0 must preserve order across wrap.

## Test plan
Bench stub: lu_out = lu_a & lu_b.
- Reset: hold rst_n=0, then check in_ready=1, out_valid=0, count=0, out_zero=1, ops_done=0. Release rst_n; all values hold with in_valid=0.
- Single op: push a=0x0000FFFF, b=0xFFFFFFFF, sel=3'b010. lu_sel=010 one cycle later. out_valid after 2 edges, out_result=0x0000FFFF, out_sel=010, out_zero=0. Pulse out_ready, then out_valid=0 and ops_done=1.
- Streaming: 8 back-to-back pushes of sel=000..111 with a=0 and b=0xFFFFFFFF, out_ready=1. Results arrive on consecutive cycles in order, all out_zero=1, count never exceeds 1, ops_done=8.
- Backpressure/full: out_ready=0 and push 6 ops. 5 are accepted (1 in the result register, 4 in the FIFO). count=4, in_ready=0. The 6th is held until out_ready=1; in_ready returns next cycle, and order is preserved.
- Simultaneous push/pop at count=2 with out_ready=1: count stays 2. Repeat for 2×DEPTH cycles across pointer wrap; no loss or reorder.
- Reset mid-stream: with count=3 and out_valid=1, drop rst_n asynchronously between edges. Outputs clear immediately; after release, the first new push yields the first new result with no stale data.

Source files
------------

// File: rtl/logic_issue_stage.sv
// Issue stage for logic_u: DEPTH-entry op FIFO feeding logic_u combinationally,
// with a registered valid/ready result port carrying the opcode and a zero flag.
module logic_issue_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [WIDTH-1:0]        i_in_a,
    input  logic [WIDTH-1:0]        i_in_b,
    input  logic [2:0]              i_in_sel,
    output logic [WIDTH-1:0]        o_lu_a,
    output logic [WIDTH-1:0]        o_lu_b,
    output logic [2:0]              o_lu_sel,
    input  logic [WIDTH-1:0]        i_lu_out,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [WIDTH-1:0]        o_out_result,
    output logic [2:0]              o_out_sel,
    output logic                    o_out_zero,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic [15:0]             o_ops_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       sel;
    } op_t;

    op_t              r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic [2:0]       r_out_sel;
    logic             r_out_zero;
    logic [15:0]      r_ops_done;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_load;
    logic w_take;
    op_t  w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    // Ready depends only on occupancy: a pop in the same cycle does not free a slot early.
    assign w_push  = i_in_valid & ~w_full;
    assign w_take  = r_out_valid & i_out_ready;
    assign w_load  = ~w_empty & (~r_out_valid | i_out_ready);
    assign w_head  = w_empty ? '0 : r_mem[r_rd_ptr];

    assign o_in_ready   = ~w_full;
    assign o_lu_a       = w_head.a;
    assign o_lu_b       = w_head.b;
    assign o_lu_sel     = w_head.sel;
    assign o_out_valid  = r_out_valid;
    assign o_out_result = r_out_result;
    assign o_out_sel    = r_out_sel;
    assign o_out_zero   = r_out_zero;
    assign o_count      = r_count;
    assign o_ops_done   = r_ops_done;

    // Storage needs no reset; empty entries are masked by w_empty.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= '{a: i_in_a, b: i_in_b, sel: i_in_sel};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_sel    <= '0;
            r_out_zero   <= 1'b1;
            r_ops_done   <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_load)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_load)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_load)
                r_count <= r_count - 1'b1;

            if (w_load) begin
                r_out_valid  <= 1'b1;
                r_out_result <= i_lu_out;
                r_out_sel    <= w_head.sel;
                r_out_zero   <= (i_lu_out == '0);
            end else if (w_take) begin
                r_out_valid  <= 1'b0;
            end

            if (w_take)
                r_ops_done <= r_ops_done + 1'b1;
        end
    end
endmodule

// File: tb/tb_logic_issue_stage.sv
// Bench for logic_issue_stage: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_logic_issue_stage;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [2:0]       in_sel = '0;
    logic [WIDTH-1:0] lu_a, lu_b, lu_out;
    logic [2:0]       lu_sel;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_sel;
    logic             out_zero;
    logic [$clog2(DEPTH):0] count;
    logic [15:0]      ops_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Stub logic unit
    assign lu_out = lu_a & lu_b;

    logic_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_a(in_a), .i_in_b(in_b), .i_in_sel(in_sel),
        .o_lu_a(lu_a), .o_lu_b(lu_b), .o_lu_sel(lu_sel),
        .i_lu_out(lu_out),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_result(out_result), .o_out_sel(out_sel), .o_out_zero(out_zero),
        .o_count(count), .o_ops_done(ops_done)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       sel;
    } op_t;

    // Reference model: queue of pending ops plus one result slot.
    op_t              mq[$];
    logic             m_v    = 1'b0;
    logic [WIDTH-1:0] m_res  = '0;
    logic [2:0]       m_sel  = '0;
    logic             m_zero = 1'b1;
    int               m_ops  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_v = 1'b0; m_res = '0; m_sel = '0; m_zero = 1'b1; m_ops = 0;
        end else begin
            bit do_push, do_load, do_take;
            op_t h;
            do_push = in_valid && (mq.size() < DEPTH);
            do_load = (mq.size() != 0) && (!m_v || out_ready);
            do_take = m_v && out_ready;
            if (do_take) m_ops = (m_ops + 1) % 65536;
            if (do_load) begin
                h = mq.pop_front();
                m_res = h.a & h.b; m_sel = h.sel; m_zero = ((h.a & h.b) == 0); m_v = 1'b1;
            end else if (do_take) begin
                m_v = 1'b0;
            end
            if (do_push) mq.push_back('{in_a, in_b, in_sel});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [WIDTH-1:0] ea, eb;
            logic [2:0] es;
            ea = '0; eb = '0; es = '0;
            if (mq.size() != 0) begin ea = mq[0].a; eb = mq[0].b; es = mq[0].sel; end
            chk("m_lu_a", 64'(lu_a), 64'(ea));
            chk("m_lu_b", 64'(lu_b), 64'(eb));
            chk("m_lu_sel", 64'(lu_sel), 64'(es));
            chk("m_in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
            chk("m_count", 64'(count), 64'(mq.size()));
            chk("m_out_valid", 64'(out_valid), 64'(m_v));
            chk("m_out_result", 64'(out_result), 64'(m_res));
            chk("m_out_sel", 64'(out_sel), 64'(m_sel));
            chk("m_out_zero", 64'(out_zero), 64'(m_zero));
            chk("m_ops_done", 64'(ops_done), 64'(m_ops));
        end
    end

    task automatic set_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] s);
        in_valid = 1'b1; in_a = a; in_b = b; in_sel = s;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_a = 'x; in_b = 'x; in_sel = 'x;
    endtask

    initial begin
        int base;
        // Reset
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd1);
        chk("rst_ops_done", 64'(ops_done), 64'd0);
        chk("rst_lu_a", 64'(lu_a), 64'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_count", 64'(count), 64'd0);

        // Single op
        set_op(32'h0000FFFF, 32'hFFFFFFFF, 3'b010);
        @(negedge clk);
        idle_in();
        chk("single_lu_sel", 64'(lu_sel), 64'd2);
        chk("single_not_yet_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_result", 64'(out_result), 64'h0000FFFF);
        chk("single_sel", 64'(out_sel), 64'd2);
        chk("single_zero", 64'(out_zero), 64'd0);
        @(negedge clk);
        chk("single_stable", 64'(out_result), 64'h0000FFFF);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("single_drained", 64'(out_valid), 64'd0);
        chk("single_ops", 64'(ops_done), 64'd1);

        // Streaming
        base = int'(ops_done);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_op('0, 32'hFFFFFFFF, 3'(i));
            @(negedge clk);
            chk("stream_count_le1", 64'(count <= 1), 64'd1);
            if (i > 0) begin
                chk("stream_valid", 64'(out_valid), 64'd1);
                chk("stream_sel", 64'(out_sel), 64'(i - 1));
                chk("stream_zero", 64'(out_zero), 64'd1);
            end
        end
        idle_in();
        repeat (3) @(negedge clk);
        chk("stream_ops", 64'(ops_done), 64'(base + 8));

        // Backpressure / full
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_op(32'h100 + 32'(i), 32'hFFFFFFFF, 3'(i));
            @(negedge clk);
        end
        set_op(32'h105, 32'hFFFFFFFF, 3'd5);
        chk("bp_count_full", 64'(count), 64'd4);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_head_result", 64'(out_result), 64'h100);
        @(negedge clk);
        chk("bp_still_full", 64'(count), 64'd4);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        chk("bp_count3", 64'(count), 64'd3);
        chk("bp_next_result", 64'(out_result), 64'h101);
        @(negedge clk);
        idle_in();
        repeat (8) @(negedge clk);
        chk("bp_last_result", 64'(out_result), 64'h105);
        chk("bp_empty", 64'(count), 64'd0);

        // Simultaneous push/pop at count=2 across pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(32'h200 + 32'(i), 32'hFFFF0FFF, 3'(i));
            @(negedge clk);
        end
        chk("pp_count2", 64'(count), 64'd2);
        out_ready = 1'b1;
        for (int i = 3; i < 3 + 2 * DEPTH; i++) begin
            set_op(32'h200 + 32'(i), 32'hFFFF0FFF, 3'(i));
            @(negedge clk);
            chk("pp_count_hold", 64'(count), 64'd2);
            chk("pp_order", 64'(out_result), 64'(32'h200 + 32'(i - 2)));
        end
        idle_in();
        repeat (4) @(negedge clk);

        // Reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_op(32'h300 + 32'(i), 32'hFFFFFFFF, 3'(i));
            @(negedge clk);
        end
        idle_in();
        chk("mr_count3", 64'(count), 64'd3);
        chk("mr_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async_valid", 64'(out_valid), 64'd0);
        chk("mr_async_count", 64'(count), 64'd0);
        chk("mr_async_ready", 64'(in_ready), 64'd1);
        chk("mr_async_lu_sel", 64'(lu_sel), 64'd0);
        chk("mr_async_zero", 64'(out_zero), 64'd1);
        chk("mr_async_result", 64'(out_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_op(32'hF0F0F0F0, 32'hFF00FF00, 3'd5);
        @(negedge clk);
        idle_in();
        chk("mr_new_lu_a", 64'(lu_a), 64'hF0F0F0F0);
        @(negedge clk);
        chk("mr_new_valid", 64'(out_valid), 64'd1);
        chk("mr_new_result", 64'(out_result), 64'hF000F000);
        chk("mr_new_sel", 64'(out_sel), 64'd5);
        chk("mr_new_ops", 64'(ops_done), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("mr_new_drain", 64'(out_valid), 64'd0);
        chk("mr_new_ops1", 64'(ops_done), 64'd1);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: bench did not finish, required completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
